// File: rtl/led_blink_pkg.sv
// led_blink_pkg: shared mode encoding and constants for the LED blink array
package led_blink_pkg;
    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } mode_t;
    localparam mode_t RST_MODE = MODE_BLINK;
    localparam int TOGGLE_CNT_W = 32;
endpackage

// File: rtl/led_blink_chan.sv
// led_blink_chan: one LED channel (mode/period/duty, counter, registered led and wrap); LED_BLINK_TOGGLE_CNT_EN adds a transition counter
module led_blink_chan
    import led_blink_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 arst_i,
    input  logic                 tick,
    input  logic                 wr,
    input  logic [1:0]           mode_in,
    input  logic [CNT_WIDTH-1:0] period_in,
    input  logic [CNT_WIDTH-1:0] duty_in,
    output logic                 led,
    output logic                 wrap
`ifdef LED_BLINK_TOGGLE_CNT_EN
    ,
    output logic [TOGGLE_CNT_W-1:0] toggle_cnt
`endif
);
    mode_t                mode;
    logic [CNT_WIDTH-1:0] period, duty, cnt, cnt_inc;
    logic                 run, at_end, led_nxt, wrap_nxt;

    // next counter/led/wrap values for a non-write cycle; OFF and ON never run the counter
    always_comb begin
        run      = (mode == MODE_BLINK || mode == MODE_PWM) && tick;
        at_end   = cnt == period;
        cnt_inc  = at_end ? '0 : cnt + CNT_WIDTH'(1);
        wrap_nxt = run && at_end;
        led_nxt  = mode == MODE_OFF ? 1'b0 :
                   mode == MODE_ON  ? 1'b1 :
                   !run             ? led :
                   mode == MODE_BLINK ? led ^ at_end : cnt_inc < duty;
    end

    // channel state; a config write overrides any tick in the same cycle
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            mode   <= RST_MODE;
            period <= '1;
            duty   <= '0;
            cnt    <= '0;
            led    <= 1'b0;
            wrap   <= 1'b0;
        end else if (wr) begin
            mode   <= mode_t'(mode_in);
            period <= period_in;
            duty   <= duty_in;
            cnt    <= '0;
            led    <= mode_in == MODE_ON;
            wrap   <= 1'b0;
        end else begin
            cnt    <= run ? cnt_inc : cnt;
            led    <= led_nxt;
            wrap   <= wrap_nxt;
        end
    end

`ifdef LED_BLINK_TOGGLE_CNT_EN
    // saturating count of led transitions, cleared by any write to this channel
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i)
            toggle_cnt <= '0;
        else if (wr)
            toggle_cnt <= '0;
        else if (led_nxt != led && toggle_cnt != '1)
            toggle_cnt <= toggle_cnt + TOGGLE_CNT_W'(1);
    end
`endif
endmodule

// File: rtl/led_blink_array.sv
// led_blink_array: NUM_CH LED channels sharing one prescaler, with a valid/ready config port; LED_BLINK_TOGGLE_CNT_EN adds toggle_cnt_o
module led_blink_array
    import led_blink_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int CNT_WIDTH = 16,
    parameter int PRESCALE  = 1,
    localparam int CH_W     = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk_i,
    input  logic                 arst_i,
    input  logic                 cfg_valid_i,
    output logic                 cfg_ready_o,
    input  logic [CH_W-1:0]      cfg_chan_i,
    input  logic [1:0]           cfg_mode_i,
    input  logic [CNT_WIDTH-1:0] cfg_period_i,
    input  logic [CNT_WIDTH-1:0] cfg_duty_i,
    output logic                 cfg_err_o,
    output logic [NUM_CH-1:0]    led_o,
    output logic [NUM_CH-1:0]    wrap_o
`ifdef LED_BLINK_TOGGLE_CNT_EN
    ,
    output logic [NUM_CH*TOGGLE_CNT_W-1:0] toggle_cnt_o
`endif
);
    localparam int PSC_W = PRESCALE > 1 ? $clog2(PRESCALE) : 1;

    logic [PSC_W-1:0] psc;
    logic             tick, accept;

    assign tick   = psc == PSC_W'(PRESCALE - 1);
    assign accept = cfg_valid_i && cfg_ready_o;

    // free-running prescaler; with PRESCALE=1 it stays at 0 and tick is constant 1
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i)
            psc <= '0;
        else
            psc <= tick ? '0 : psc + PSC_W'(1);
    end

    // ready rises one edge after reset release; out-of-range writes are accepted and flagged
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            cfg_ready_o <= 1'b0;
            cfg_err_o   <= 1'b0;
        end else begin
            cfg_ready_o <= 1'b1;
            cfg_err_o   <= accept && (int'(cfg_chan_i) >= NUM_CH);
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        led_blink_chan #(.CNT_WIDTH(CNT_WIDTH)) u_chan (
            .clk_i     (clk_i),
            .arst_i    (arst_i),
            .tick      (tick),
            .wr        (accept && cfg_chan_i == CH_W'(c)),
            .mode_in   (cfg_mode_i),
            .period_in (cfg_period_i),
            .duty_in   (cfg_duty_i),
            .led       (led_o[c]),
            .wrap      (wrap_o[c])
`ifdef LED_BLINK_TOGGLE_CNT_EN
            ,
            .toggle_cnt(toggle_cnt_o[c*TOGGLE_CNT_W +: TOGGLE_CNT_W])
`endif
        );
    end
endmodule

// File: tb/tb_led_blink_array.sv
// tb_led_blink_array: directed table-driven check of led_blink_array (4ch/PRESCALE=1 and 3ch/PRESCALE=3)
module tb_led_blink_array;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid_a = 1'b0, valid_b = 1'b0;
    logic [1:0] chan = '0, mode = '0;
    logic [3:0] period = '0, duty = '0;
    logic       ready_a, err_a, ready_b, err_b;
    logic [3:0] led_a, wrap_a;
    logic [2:0] led_b, wrap_b;
`ifdef LED_BLINK_TOGGLE_CNT_EN
    logic [127:0] tc_a;
    logic [95:0]  tc_b;
`endif
    int n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    led_blink_array #(.NUM_CH(4), .CNT_WIDTH(4), .PRESCALE(1)) u_a (
        .clk_i(clk), .arst_i(rst), .cfg_valid_i(valid_a), .cfg_ready_o(ready_a),
        .cfg_chan_i(chan), .cfg_mode_i(mode), .cfg_period_i(period), .cfg_duty_i(duty),
        .cfg_err_o(err_a), .led_o(led_a), .wrap_o(wrap_a)
`ifdef LED_BLINK_TOGGLE_CNT_EN
        , .toggle_cnt_o(tc_a)
`endif
    );

    led_blink_array #(.NUM_CH(3), .CNT_WIDTH(4), .PRESCALE(3)) u_b (
        .clk_i(clk), .arst_i(rst), .cfg_valid_i(valid_b), .cfg_ready_o(ready_b),
        .cfg_chan_i(chan), .cfg_mode_i(mode), .cfg_period_i(period), .cfg_duty_i(duty),
        .cfg_err_o(err_b), .led_o(led_b), .wrap_o(wrap_b)
`ifdef LED_BLINK_TOGGLE_CNT_EN
        , .toggle_cnt_o(tc_b)
`endif
    );

    typedef struct {
        int         adv;
        logic       wr;
        logic [1:0] ch;
        logic [1:0] md;
        logic [3:0] per;
        logic [3:0] dty;
        logic [3:0] led;
        logic [3:0] wrap;
    } vec_t;

    vec_t tbl [0:26];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int tog_a[4], tog_b[3], wr_a, wr_b;
        logic [3:0] prev_a;
        logic [2:0] prev_b;
        // adv = edges advanced (first edge carries the write if wr), then led/wrap of the 4-ch instance
        tbl[0]  = '{15, 1'b0, 2'd0, 2'd0, 4'd0, 4'd0,  4'b0000, 4'b0000};
        tbl[1]  = '{1,  1'b0, 2'd0, 2'd0, 4'd0, 4'd0,  4'b1111, 4'b1111};
        tbl[2]  = '{1,  1'b0, 2'd0, 2'd0, 4'd0, 4'd0,  4'b1111, 4'b0000};
        tbl[3]  = '{15, 1'b0, 2'd0, 2'd0, 4'd0, 4'd0,  4'b0000, 4'b1111};
        tbl[4]  = '{1,  1'b1, 2'd2, 2'd3, 4'd9, 4'd3,  4'b0000, 4'b0000};
        tbl[5]  = '{1,  1'b0, 2'd0, 2'd0, 4'd0, 4'd0,  4'b0100, 4'b0000};
        tbl[6]  = '{2,  1'b0, 2'd0, 2'd0, 4'd0, 4'd0,  4'b0000, 4'b0000};
        tbl[7]  = '{7,  1'b0, 2'd0, 2'd0, 4'd0, 4'd0,  4'b0100, 4'b0100};
        tbl[8]  = '{2,  1'b0, 2'd0, 2'd0, 4'd0, 4'd0,  4'b0100, 4'b0000};
        tbl[9]  = '{1,  1'b0, 2'd0, 2'd0, 4'd0, 4'd0,  4'b0000, 4'b0000};
        tbl[10] = '{2,  1'b0, 2'd0, 2'd0, 4'd0, 4'd0,  4'b1011, 4'b1011};
        tbl[11] = '{5,  1'b0, 2'd0, 2'd0, 4'd0, 4'd0,  4'b1111, 4'b0100};
        tbl[12] = '{1,  1'b1, 2'd2, 2'd3, 4'd9, 4'd0,  4'b1011, 4'b0000};
        tbl[13] = '{10, 1'b0, 2'd0, 2'd0, 4'd0, 4'd0,  4'b0000, 4'b1111};
        tbl[14] = '{1,  1'b1, 2'd2, 2'd3, 4'd9, 4'd12, 4'b0000, 4'b0000};
        tbl[15] = '{1,  1'b0, 2'd0, 2'd0, 4'd0, 4'd0,  4'b0100, 4'b0000};
        tbl[16] = '{9,  1'b0, 2'd0, 2'd0, 4'd0, 4'd0,  4'b0100, 4'b0100};
        tbl[17] = '{10, 1'b0, 2'd0, 2'd0, 4'd0, 4'd0,  4'b1111, 4'b0100};
        tbl[18] = '{1,  1'b1, 2'd0, 2'd0, 4'd0, 4'd0,  4'b1110, 4'b0000};
        tbl[19] = '{10, 1'b0, 2'd0, 2'd0, 4'd0, 4'd0,  4'b0100, 4'b1010};
        tbl[20] = '{1,  1'b1, 2'd0, 2'd1, 4'd0, 4'd0,  4'b0101, 4'b0000};
        tbl[21] = '{15, 1'b0, 2'd0, 2'd0, 4'd0, 4'd0,  4'b1111, 4'b1010};
        tbl[22] = '{15, 1'b0, 2'd0, 2'd0, 4'd0, 4'd0,  4'b1111, 4'b0000};
        tbl[23] = '{1,  1'b1, 2'd3, 2'd2, 4'd3, 4'd0,  4'b0101, 4'b0010};
        tbl[24] = '{3,  1'b0, 2'd0, 2'd0, 4'd0, 4'd0,  4'b0101, 4'b0000};
        tbl[25] = '{1,  1'b0, 2'd0, 2'd0, 4'd0, 4'd0,  4'b1101, 4'b1000};
        tbl[26] = '{4,  1'b0, 2'd0, 2'd0, 4'd0, 4'd0,  4'b0101, 4'b1000};

        step(2);
        chk("rst led_a", led_a, 0);
        chk("rst wrap_a", wrap_a, 0);
        chk("rst ready_a", ready_a, 0);
        chk("rst err_a", err_a, 0);
        chk("rst led_b", led_b, 0);
        chk("rst ready_b", ready_b, 0);
        rst = 1'b0;
        #1;
        chk("ready before first edge", ready_a, 0);

        for (int i = 0; i < 27; i++) begin
            valid_a = tbl[i].wr;
            chan    = tbl[i].ch;
            mode    = tbl[i].md;
            period  = tbl[i].per;
            duty    = tbl[i].dty;
            step(1);
            valid_a = 1'b0;
            if (tbl[i].adv > 1) step(tbl[i].adv - 1);
            chk($sformatf("vec%0d led", i), led_a, tbl[i].led);
            chk($sformatf("vec%0d wrap", i), wrap_a, tbl[i].wrap);
        end
        chk("ready_a after writes", ready_a, 1);
        chk("err_a never", err_a, 0);

        #1 rst = 1'b1;
        #1;
        chk("async rst led_a", led_a, 0);
        chk("async rst wrap_a", wrap_a, 0);
        chk("async rst ready_a", ready_a, 0);
        step(2);
        rst = 1'b0;

        prev_a = led_a;
        prev_b = led_b;
        wr_a = 0;
        wr_b = 0;
        foreach (tog_a[c]) tog_a[c] = 0;
        foreach (tog_b[c]) tog_b[c] = 0;
        for (int k = 0; k < 1000; k++) begin
            step(1);
            for (int c = 0; c < 4; c++) tog_a[c] += int'(led_a[c] != prev_a[c]);
            for (int c = 0; c < 3; c++) tog_b[c] += int'(led_b[c] != prev_b[c]);
            wr_a += int'(wrap_a[0]);
            wr_b += int'(wrap_b[0]);
            prev_a = led_a;
            prev_b = led_b;
        end
        for (int c = 0; c < 4; c++) chk($sformatf("default toggles a ch%0d", c), tog_a[c], 62);
        for (int c = 0; c < 3; c++) chk($sformatf("default toggles b ch%0d", c), tog_b[c], 20);
        chk("default wraps a", wr_a, 62);
        chk("default wraps b", wr_b, 20);
`ifdef LED_BLINK_TOGGLE_CNT_EN
        for (int c = 0; c < 4; c++) chk($sformatf("toggle_cnt a ch%0d", c), tc_a[c*32 +: 32], 62);
        for (int c = 0; c < 3; c++) chk($sformatf("toggle_cnt b ch%0d", c), tc_b[c*32 +: 32], 20);
`endif

        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(2);
        chk("b ready", ready_b, 1);
        valid_b = 1'b1;
        chan    = 2'd1;
        mode    = 2'd2;
        period  = 4'd4;
        duty    = 4'd0;
        step(1);
        valid_b = 1'b0;
        step(14);
        chk("b E17 led", led_b, 3'b000);
        step(1);
        chk("b E18 led", led_b, 3'b010);
        chk("b E18 wrap", wrap_b, 3'b010);
        step(1);
        chk("b E19 wrap", wrap_b, 3'b000);
        step(14);
        chk("b E33 led", led_b, 3'b000);
        chk("b E33 wrap", wrap_b, 3'b010);
        step(14);
        chk("b E47 led", led_b, 3'b000);
        step(1);
        chk("b E48 led", led_b, 3'b111);
        chk("b E48 wrap", wrap_b, 3'b111);
        step(1);
        chk("b E49 wrap", wrap_b, 3'b000);
        valid_b = 1'b1;
        chan    = 2'd3;
        mode    = 2'd0;
        step(1);
        valid_b = 1'b0;
        chk("b err pulse", err_b, 1);
        chk("b err no led change", led_b, 3'b111);
        chk("a err untouched", err_a, 0);
        step(1);
        chk("b err clears", err_b, 0);
        step(12);
        chk("b E63 led", led_b, 3'b101);
        chk("b E63 wrap", wrap_b, 3'b010);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/led_blink_array.md
Name: led_blink_array

Overview:
- Multi-channel successor to the single-LED free-running blinker; drives NUM_CH LED outputs from one shared prescaler.
- Each channel has a runtime-programmable mode (OFF, ON, BLINK, PWM), period and duty, written over a valid/ready config port.
- Out of reset every channel behaves as the legacy blinker, toggling every 2**CNT_WIDTH ticks; existing boards work unchanged.

Parameters:
- NUM_CH, 4, number of LED channels (1..16).
- CNT_WIDTH, 16, width of the per-channel counter, period and duty.
- PRESCALE, 1, clk_i cycles per tick (>=1).
- CH_W, $clog2(NUM_CH) (min 1), channel index width (derived localparam).

Ports:
- clk_i  in  1  system clock.
- arst_i  in  1  asynchronous reset, active-high.
- cfg_valid_i  in  1  config write request.
- cfg_ready_o  out  1  config write accepted when valid&ready.
- cfg_chan_i  in  CH_W  target channel.
- cfg_mode_i  in  2  0=OFF 1=ON 2=BLINK 3=PWM.
- cfg_period_i  in  CNT_WIDTH  counter terminal value.
- cfg_duty_i  in  CNT_WIDTH  PWM high count.
- cfg_err_o  out  1  1-cycle pulse: accepted write had cfg_chan_i >= NUM_CH.
- led_o  out  NUM_CH  registered LED outputs.
- wrap_o  out  NUM_CH  1-cycle pulse per channel on counter wrap.

Behaviour:
- Reset values (async on arst_i, takes effect immediately):
  - led_o=0, wrap_o=0, cfg_err_o=0, cfg_ready_o=0, prescaler=0.
  - Every channel: mode=BLINK, period=2**CNT_WIDTH-1, duty=0, cnt=0.
- Reset mid-operation aborts all state, including any handshake in flight; no partial config is retained.
- cfg_ready_o goes to 1 on the first clock edge after arst_i deasserts and stays 1; a write is accepted in any cycle with valid&ready.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps.
  - tick=1 in the cycle the prescaler equals PRESCALE-1; with PRESCALE=1, tick is constant 1.
- Per-channel counter: advances only on tick. When cnt==period it wraps to 0; otherwise it increments. period=0 means a wrap on every tick.
- OFF: led=0, cnt held at 0, wrap_o never fires.
- ON: led=1, cnt held at 0, wrap_o never fires.
- BLINK: on each wrap led toggles and wrap_o pulses. Toggle interval = (period+1)*PRESCALE clk cycles.
- PWM:
  - Counter runs as in BLINK; wrap_o pulses on each wrap.
  - led = (next cnt < duty), registered.
  - duty=0 gives constant 0; duty>period gives constant 1.
- Latency: led_o and wrap_o are registered, 1 cycle after the tick edge that causes the change.
- Config write to channel c takes effect at the accepting edge:
  - mode/period/duty loaded; cnt=0; led=0 (ON sets led=1); wrap_o[c]=0 that cycle.
  - A write and a tick in the same cycle on the same channel: the write wins and the tick is discarded for that channel only.
  - Other channels are unaffected by the write.
- Out-of-range channel (non-power-of-2 NUM_CH): the write is accepted, no state changes, cfg_err_o pulses the next cycle.
- Counter arithmetic is unsigned CNT_WIDTH. The wrap at all-ones never overflows because cnt<=period always holds.

Optional Feature:
- Macro LED_BLINK_TOGGLE_CNT_EN.
- Defined:
  - Adds output toggle_cnt_o [NUM_CH*32]: per-channel count of led_o transitions.
  - Counter saturates at 32'hFFFF_FFFF.
  - Cleared by reset and by any config write to that channel.
  - Updates in the same cycle led_o changes.
- Undefined: the port and counters do not exist; all other behaviour is identical.

Decomposition:
- Package led_blink_pkg:
  - mode typedef with MODE_OFF/ON/BLINK/PWM.
  - Reset-mode constant (MODE_BLINK).
  - Toggle counter width constant TOGGLE_CNT_W=32.
- One sub-module led_blink_chan, generated NUM_CH times:
  - Holds mode/period/duty/cnt/led/wrap (plus optional toggle counter).
  - Inputs: tick, write strobe, config fields.
- The top holds the prescaler, handshake, channel decode and error flag.

Test Plan:
- Reset default, NUM_CH=4, CNT_WIDTH=4, PRESCALE=1:
  - Release reset, no writes.
  - All led_o toggle together every 16 cycles; wrap_o pulses every 16 cycles.
  - Over 1000 cycles: 62 toggles per channel (toggle_cnt_o=62 with feature on).
- BLINK, PRESCALE=3:
  - Write ch1 BLINK period=4.
  - led_o[1] toggles every 15 cycles, first toggle 15 cycles after the write edge.
  - Other channels are undisturbed.
- PWM:
  - Write ch2 PWM period=9 duty=3: led_o[2] high 3 of every 10 ticks, repeating pattern.
  - duty=0: constant 0. duty=12: constant 1, with wrap_o still pulsing every 10 ticks.
- OFF/ON and collision:
  - Write ch0 OFF then ON: led_o[0] is 0 then 1 one cycle after each write; no wrap_o pulses.
  - Write ch3 on the exact cycle its counter would wrap: no toggle, cnt restarts at 0.
- Reset mid-operation and error:
  - Assert arst_i asynchronously mid-PWM: outputs go to 0 immediately; after release, channels are back in the default BLINK mode.
  - NUM_CH=3, write chan=3: cfg_err_o pulses once, no LED changes.
